// File: rtl/branch_exec_unit.sv
// Branch execution unit: resolves I/B/LR/CTR/TAR-form branches, owns LR and CTR,
// tracks the current instruction address and keeps a circular return-address stack.
module branch_exec_unit #(
  parameter int                ADDR_W     = 64,
  parameter int                RAS_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_32b_mode,
  input  logic              i_stall,
  input  logic              i_en,
  input  logic [31:0]       i_instr,
  input  logic              i_i_form,
  input  logic              i_b_form,
  input  logic              i_cond_LR,
  input  logic              i_cond_CTR,
  input  logic              i_cond_TAR,
  input  logic [31:0]       i_condition_register,
  input  logic [ADDR_W-1:0] i_target_address_register,
  input  logic              i_lr_we,
  input  logic [ADDR_W-1:0] i_lr_wdata,
  input  logic              i_ctr_we,
  input  logic [ADDR_W-1:0] i_ctr_wdata,
  output logic [ADDR_W-1:0] o_next_instr_addr,
  output logic [ADDR_W-1:0] o_link_register,
  output logic [ADDR_W-1:0] o_count_register,
  output logic              o_taken,
  output logic [ADDR_W-1:0] o_ras_top,
  output logic              o_ras_valid,
  output logic              o_ras_mismatch,
  output logic              err_branch_on_stall
);
  localparam int               PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] r_cia, r_lr, r_ctr;
  logic              r_boot, r_taken, r_mismatch;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_cnt;

  // Instruction fields; IBM bit k of the instruction is i_instr[31-k].
  logic [4:0]  w_bo, w_bi;
  logic [13:0] w_bd;
  logic [23:0] w_li;
  logic [1:0]  w_bh;
  logic        w_aa, w_lk;
  assign w_bo = i_instr[25:21];
  assign w_bi = i_instr[20:16];
  assign w_bd = i_instr[15:2];
  assign w_li = i_instr[25:2];
  assign w_bh = i_instr[12:11];
  assign w_aa = i_instr[1];
  assign w_lk = i_instr[0];

  logic [ADDR_W-1:0] w_mask, w_cia4, w_link, w_base, w_ctr_m, w_target, w_nia, w_ras_top;
  logic              w_branch, w_acc, w_decr, w_ctr_nz, w_ctr_ok, w_cond_ok, w_taken;
  logic              w_bh_zero, w_pop, w_push, w_pop_eff;
  logic [PTR_W-1:0]  w_top_idx, w_ptr_pop;
  logic [CNT_W-1:0]  w_cnt_pop;
  logic              w_unused;

  assign w_mask   = i_32b_mode ? ADDR_W'(64'h0000_0000_FFFF_FFFF) : '1;
  assign w_cia4   = r_cia + ADDR_W'(4);
  assign w_link   = w_cia4 & w_mask;
  assign w_base   = w_aa ? '0 : r_cia;
  // No instruction can be in flight before the first fetch, so the boot cycle ignores i_en.
  assign w_branch = i_en & ~r_boot;
  assign w_acc    = w_branch & ~i_stall;

  assign w_decr    = ~w_bo[2] & (i_b_form | i_cond_LR | i_cond_TAR);
  assign w_ctr_m   = w_decr ? r_ctr - ADDR_W'(1) : r_ctr;
  assign w_ctr_nz  = i_32b_mode ? (w_ctr_m[31:0] != 32'd0) : (w_ctr_m != '0);
  assign w_ctr_ok  = w_bo[2] | (w_ctr_nz ^ w_bo[1]);
  assign w_cond_ok = w_bo[4] | (i_condition_register[5'd31 - w_bi] == w_bo[3]);
  assign w_taken   = i_i_form | (w_ctr_ok & w_cond_ok);

  always_comb begin
    w_target = w_cia4;
    if (i_i_form)
      w_target = {{(ADDR_W-26){w_li[23]}}, w_li, 2'b00} + w_base;
    else if (i_b_form)
      w_target = {{(ADDR_W-16){w_bd[13]}}, w_bd, 2'b00} + w_base;
    else if (i_cond_LR)
      w_target = {r_lr[ADDR_W-1:2], 2'b00};
    else if (i_cond_CTR)
      w_target = {r_ctr[ADDR_W-1:2], 2'b00};
    else if (i_cond_TAR)
      w_target = {i_target_address_register[ADDR_W-1:2], 2'b00};
  end

  assign w_nia = (r_boot ? r_cia : ((w_branch && w_taken) ? w_target : w_cia4)) & w_mask;

  // Return-address stack: pop is applied first so bclrl replaces the top in place.
  assign w_bh_zero = (w_bh == 2'b00);
  assign w_pop     = w_acc & w_taken & i_cond_LR & w_bh_zero;
  assign w_push    = w_acc & w_taken & w_lk & (~i_cond_LR | w_bh_zero);
  assign w_top_idx = r_ptr - 1'b1;
  assign w_ras_top = r_ras[w_top_idx];
  assign w_pop_eff = w_pop & o_ras_valid;
  assign w_ptr_pop = w_pop_eff ? w_top_idx : r_ptr;
  assign w_cnt_pop = w_pop_eff ? r_cnt - 1'b1 : r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cia      <= RESET_ADDR;
      r_lr       <= '0;
      r_ctr      <= '0;
      r_boot     <= 1'b1;
      r_taken    <= 1'b0;
      r_mismatch <= 1'b0;
      r_ptr      <= '0;
      r_cnt      <= '0;
    end else if (!i_stall) begin
      r_cia      <= w_nia;
      r_boot     <= 1'b0;
      r_taken    <= w_acc & w_taken;
      r_mismatch <= w_pop & (~o_ras_valid | (w_nia != w_ras_top));
      if (w_acc && w_lk)
        r_lr <= w_link;
      else if (i_lr_we)
        r_lr <= i_lr_wdata;
      if (w_acc && w_decr)
        r_ctr <= w_ctr_m;
      else if (i_ctr_we)
        r_ctr <= i_ctr_wdata;
      if (w_push) begin
        r_ptr <= w_ptr_pop + 1'b1;
        r_cnt <= (w_cnt_pop == RAS_FULL) ? w_cnt_pop : w_cnt_pop + 1'b1;
      end else begin
        r_ptr <= w_ptr_pop;
        r_cnt <= w_cnt_pop;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push)
      r_ras[w_ptr_pop] <= w_link;
  end

  assign o_next_instr_addr   = w_nia;
  assign o_link_register     = r_lr;
  assign o_count_register    = r_ctr;
  assign o_taken             = r_taken;
  assign o_ras_top           = w_ras_top;
  assign o_ras_valid         = (r_cnt != '0);
  assign o_ras_mismatch      = r_mismatch;
  assign err_branch_on_stall = i_stall & i_en;
  assign w_unused            = ^{i_instr[31:26], i_target_address_register[1:0]};
endmodule

// File: tb/tb_branch_exec_unit.sv
// Directed bench for branch_exec_unit: hand-computed fetch addresses, LR/CTR values
// and return-address-stack behaviour, checked with immediate assertions.
module tb_branch_exec_unit;
  logic        i_clk = 1'b0;
  logic        i_rst, i_32b_mode, i_stall, i_en;
  logic [31:0] i_instr;
  logic        i_i_form, i_b_form, i_cond_LR, i_cond_CTR, i_cond_TAR;
  logic [31:0] i_condition_register;
  logic [63:0] i_target_address_register, i_lr_wdata, i_ctr_wdata;
  logic        i_lr_we, i_ctr_we;
  logic [63:0] o_next_instr_addr, o_link_register, o_count_register, o_ras_top;
  logic        o_taken, o_ras_valid, o_ras_mismatch, err_branch_on_stall;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_addr;

  branch_exec_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_32b_mode(i_32b_mode), .i_stall(i_stall), .i_en(i_en),
    .i_instr(i_instr), .i_i_form(i_i_form), .i_b_form(i_b_form), .i_cond_LR(i_cond_LR),
    .i_cond_CTR(i_cond_CTR), .i_cond_TAR(i_cond_TAR), .i_condition_register(i_condition_register),
    .i_target_address_register(i_target_address_register), .i_lr_we(i_lr_we),
    .i_lr_wdata(i_lr_wdata), .i_ctr_we(i_ctr_we), .i_ctr_wdata(i_ctr_wdata),
    .o_next_instr_addr(o_next_instr_addr), .o_link_register(o_link_register),
    .o_count_register(o_count_register), .o_taken(o_taken), .o_ras_top(o_ras_top),
    .o_ras_valid(o_ras_valid), .o_ras_mismatch(o_ras_mismatch),
    .err_branch_on_stall(err_branch_on_stall)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_en = 1'b0; i_i_form = 1'b0; i_b_form = 1'b0;
    i_cond_LR = 1'b0; i_cond_CTR = 1'b0; i_cond_TAR = 1'b0;
    i_lr_we = 1'b0; i_ctr_we = 1'b0; i_instr = 32'd0;
  endtask

  function automatic logic [31:0] enc_i(input logic [23:0] li, input logic aa, input logic lk);
    return {6'd18, li, aa, lk};
  endfunction

  function automatic logic [31:0] enc_b(input logic [4:0] bo, input logic [4:0] bi,
                                        input logic [13:0] bd, input logic aa, input logic lk);
    return {6'd16, bo, bi, bd, aa, lk};
  endfunction

  function automatic logic [31:0] enc_xl(input logic [4:0] bo, input logic [1:0] bh,
                                         input logic [9:0] xo, input logic lk);
    return {6'd19, bo, 5'd0, 3'd0, bh, xo, lk};
  endfunction

  task automatic br_i(input logic [23:0] li, input logic aa, input logic lk);
    idle();
    i_en = 1'b1; i_i_form = 1'b1; i_instr = enc_i(li, aa, lk);
  endtask

  task automatic br_lr(input logic lk);
    idle();
    i_en = 1'b1; i_cond_LR = 1'b1; i_instr = enc_xl(5'b10100, 2'b00, 10'd16, lk);
  endtask

  initial begin
    idle();
    i_rst = 1'b1; i_32b_mode = 1'b0; i_stall = 1'b0;
    i_condition_register = 32'd0; i_target_address_register = 64'd0;
    i_lr_wdata = 64'd0; i_ctr_wdata = 64'd0;
    tick(); tick();
    i_rst = 1'b0;
    #1;
    chk("rst_lr", o_link_register, 64'd0);
    chk("rst_ctr", o_count_register, 64'd0);
    chk("rst_taken", {63'd0, o_taken}, 64'd0);
    chk("rst_ras_valid", {63'd0, o_ras_valid}, 64'd0);
    chk("rst_mismatch", {63'd0, o_ras_mismatch}, 64'd0);
    chk("boot_nia", o_next_instr_addr, 64'd0);
    tick(); chk("seq_nia4", o_next_instr_addr, 64'd4);
    tick(); chk("seq_nia8", o_next_instr_addr, 64'd8);
    tick(); chk("seq_nia12", o_next_instr_addr, 64'd12);

    // Absolute jump to 0x100, then relative bl from there
    br_i(24'h40, 1'b1, 1'b0); #1;
    chk("ba_nia", o_next_instr_addr, 64'h100);
    tick(); idle(); #1;
    chk("ba_taken", {63'd0, o_taken}, 64'd1);
    chk("seq_after_ba", o_next_instr_addr, 64'h104);
    br_i(24'h10, 1'b0, 1'b1); #1;
    chk("bl_nia", o_next_instr_addr, 64'h140);
    tick(); idle(); #1;
    chk("bl_lr", o_link_register, 64'h104);
    chk("bl_ras_top", o_ras_top, 64'h104);
    chk("bl_ras_valid", {63'd0, o_ras_valid}, 64'd1);
    chk("bl_taken", {63'd0, o_taken}, 64'd1);

    // bdnz with CTR=1 (falls through) and CTR=2 (taken); cia=0x140
    i_ctr_we = 1'b1; i_ctr_wdata = 64'd1; tick(); idle(); #1;
    chk("mtctr1", o_count_register, 64'd1);
    i_en = 1'b1; i_b_form = 1'b1; i_instr = enc_b(5'b10000, 5'd0, 14'h10, 1'b0, 1'b0); #1;
    chk("bdnz1_nia", o_next_instr_addr, 64'h148);
    tick(); idle(); #1;
    chk("bdnz1_ctr", o_count_register, 64'd0);
    chk("bdnz1_taken", {63'd0, o_taken}, 64'd0);
    i_ctr_we = 1'b1; i_ctr_wdata = 64'd2; tick(); idle();
    i_en = 1'b1; i_b_form = 1'b1; i_instr = enc_b(5'b10000, 5'd0, 14'h10, 1'b0, 1'b0); #1;
    chk("bdnz2_nia", o_next_instr_addr, 64'h18C);
    tick(); idle(); #1;
    chk("bdnz2_ctr", o_count_register, 64'd1);
    chk("bdnz2_taken", {63'd0, o_taken}, 64'd1);

    // bl and mtlr in the same cycle: the link update wins; cia=0x18C
    br_i(24'h4, 1'b0, 1'b1); i_lr_we = 1'b1; i_lr_wdata = 64'hDEAD; #1;
    chk("prio_nia", o_next_instr_addr, 64'h19C);
    tick(); idle(); #1;
    chk("prio_lr", o_link_register, 64'h190);
    chk("prio_ras_top", o_ras_top, 64'h190);

    // bc on CR bit 2, backward displacement; cia=0x19C
    i_en = 1'b1; i_b_form = 1'b1; i_instr = enc_b(5'b01100, 5'd2, 14'h3FFF, 1'b0, 1'b0);
    i_condition_register = 32'h2000_0000; #1;
    chk("bc_cr1_nia", o_next_instr_addr, 64'h198);
    i_condition_register = 32'h0000_0000; #1;
    chk("bc_cr0_nia", o_next_instr_addr, 64'h1A0);
    tick(); idle(); #1;
    chk("bc_ctr_kept", o_count_register, 64'd1);

    // Branch during stall: flagged and ignored; cia=0x1A0
    i_stall = 1'b1; br_i(24'h4, 1'b0, 1'b1); #1;
    chk("stall_err", {63'd0, err_branch_on_stall}, 64'd1);
    tick(); i_stall = 1'b0; idle(); #1;
    chk("stall_err_clr", {63'd0, err_branch_on_stall}, 64'd0);
    chk("stall_cia", o_next_instr_addr, 64'h1A4);
    chk("stall_lr", o_link_register, 64'h190);
    chk("stall_ctr", o_count_register, 64'd1);
    chk("stall_ras_top", o_ras_top, 64'h190);
    tick();

    // bctar clears the low two target bits; cia=0x1A4
    i_en = 1'b1; i_cond_TAR = 1'b1; i_target_address_register = 64'h2003;
    i_instr = enc_xl(5'b10100, 2'b00, 10'd560, 1'b0); #1;
    chk("tar_nia", o_next_instr_addr, 64'h2000);
    tick(); idle(); #1;
    chk("tar_ctr_kept", o_count_register, 64'd1);

    // Reset while a bl is presented: nothing from the branch survives
    i_rst = 1'b1; br_i(24'h4, 1'b0, 1'b1); tick();
    i_rst = 1'b0; idle(); #1;
    chk("rstbr_lr", o_link_register, 64'd0);
    chk("rstbr_ctr", o_count_register, 64'd0);
    chk("rstbr_ras_valid", {63'd0, o_ras_valid}, 64'd0);
    chk("rstbr_nia", o_next_instr_addr, 64'd0);
    tick();

    // Nine calls overflow an 8-deep stack; the oldest return is lost
    for (int k = 0; k < 9; k++) begin
      br_i(24'h40, 1'b0, 1'b1); #1;
      chk($sformatf("call%0d_nia", k), o_next_instr_addr, 64'(k + 1) * 64'h100);
      tick();
    end
    idle(); #1;
    chk("calls_lr", o_link_register, 64'h804);
    chk("calls_ras_top", o_ras_top, 64'h804);
    for (int j = 0; j < 9; j++) begin
      exp_addr = 64'(8 - j) * 64'h100 + 64'h4;
      idle(); i_lr_we = 1'b1; i_lr_wdata = exp_addr; tick();
      br_lr(1'b0); #1;
      chk($sformatf("ret%0d_valid", j), {63'd0, o_ras_valid}, {63'd0, j < 8});
      if (j < 8) chk($sformatf("ret%0d_top", j), o_ras_top, exp_addr);
      chk($sformatf("ret%0d_nia", j), o_next_instr_addr, exp_addr);
      tick(); idle(); #1;
      chk($sformatf("ret%0d_mismatch", j), {63'd0, o_ras_mismatch}, {63'd0, j == 8});
    end
    chk("ret_empty_valid", {63'd0, o_ras_valid}, 64'd0);

    // bclrl replaces the top entry; cia=0x004
    br_i(24'h40, 1'b0, 1'b1); #1;
    chk("bl2_nia", o_next_instr_addr, 64'h104);
    tick();
    br_lr(1'b1); #1;
    chk("bclrl_nia", o_next_instr_addr, 64'h008);
    tick(); idle(); #1;
    chk("bclrl_top", o_ras_top, 64'h108);
    chk("bclrl_lr", o_link_register, 64'h108);
    chk("bclrl_valid", {63'd0, o_ras_valid}, 64'd1);
    chk("bclrl_mismatch", {63'd0, o_ras_mismatch}, 64'd0);
    br_lr(1'b0); #1;
    chk("blr2_nia", o_next_instr_addr, 64'h108);
    tick(); idle(); #1;
    chk("blr2_mismatch", {63'd0, o_ras_mismatch}, 64'd0);
    chk("blr2_valid", {63'd0, o_ras_valid}, 64'd0);

    // 32-bit mode wrap of nia and of the saved link
    i_32b_mode = 1'b1; br_i(24'hFFFFFF, 1'b1, 1'b0); #1;
    chk("m32_ba_nia", o_next_instr_addr, 64'h0000_0000_FFFF_FFFC);
    tick(); idle(); #1;
    chk("m32_wrap_nia", o_next_instr_addr, 64'd0);
    br_i(24'h1, 1'b0, 1'b1); #1;
    chk("m32_bl_nia", o_next_instr_addr, 64'd0);
    tick(); idle(); #1;
    chk("m32_bl_lr", o_link_register, 64'd0);
    chk("m32_bl_top", o_ras_top, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_exec_unit.md
BRANCH_EXEC_UNIT -- requirements
Module: branch_exec_unit

Interface
REQ-001 Parameter ADDR_W, default 64, instruction-address width; SHALL be 64 or 32.
REQ-002 Parameter RAS_DEPTH, default 8, return-address-stack entries; SHALL be a power of two, at least 2.
REQ-003 Parameter RESET_ADDR, default 0, first fetch address after reset.
REQ-004 i_clk  in  1  clock; all state SHALL update on its rising edge.
REQ-005 i_rst  in  1  reset; synchronous, active-high.
REQ-006 i_32b_mode  in  1  32-bit computation mode.
REQ-007 i_stall  in  1  hold all state; nia not consumed.
REQ-008 i_en  in  1  branch instruction valid this cycle.
REQ-009 i_instr  in  32  instruction, bit 0 MSB.
REQ-010 i_i_form, i_b_form, i_cond_LR, i_cond_CTR, i_cond_TAR  in  1 each  one-hot form select, valid with i_en.
REQ-011 i_condition_register  in  32  CR.
REQ-012 i_target_address_register  in  ADDR_W  TAR.
REQ-013 i_lr_we / i_lr_wdata  in  1 / ADDR_W  mtspr LR write.
REQ-014 i_ctr_we / i_ctr_wdata  in  1 / ADDR_W  mtspr CTR write.
REQ-015 o_next_instr_addr  out  ADDR_W  nia to fetch.
REQ-016 o_link_register, o_count_register  out  ADDR_W  architected LR and CTR, owned here.
REQ-017 o_taken  out  1  registered; high one cycle after an accepted, taken branch.
REQ-018 o_ras_top / o_ras_valid  out  ADDR_W / 1  predicted return address; valid when RAS non-empty.
REQ-019 o_ras_mismatch  out  1  registered one-cycle pulse; bclr with BH=00 whose target differs from RAS top or finds RAS empty.
REQ-020 err_branch_on_stall  out  1  combinational: i_stall & i_en.

Function
REQ-021 Fields: BO=instr[6:10], BI=[11:15], BD=[16:29], LI=[6:29], BH=[19:20], AA=[30], LK=[31].
REQ-022 Accepted branch = i_en & !i_stall; only accepted branches SHALL update cia, LR, CTR, RAS.
REQ-023 CTR decrement: B-form, LR- or TAR-form with BO[2]=0; CTR-form SHALL never decrement.
REQ-024 ctr_ok = BO[2] | ((CTR_M != 0) XOR BO[3]), with CTR_M the decremented value; cond_ok = BO[0] | (CR[BI] == BO[1]); taken = ctr_ok & cond_ok; I-form always taken.
REQ-025 In 32-bit mode, the CTR_M zero test SHALL use only the low 32 bits.
REQ-026 Targets: I-form EXTS(LI||00) (+cia if AA=0); B-form EXTS(BD||00) (+cia if AA=0); LR-form LR[0:ADDR_W-3]||00; CTR-form CTR[..]||00; TAR-form TAR[..]||00.
REQ-027 nia = target if taken, else cia+4; combinational from current inputs; adds wrap modulo 2^ADDR_W.
REQ-028 In 32-bit mode, the high 32 bits of nia and of the saved LR value SHALL be zero.
REQ-029 First cycle after reset, nia SHALL equal cia (RESET_ADDR); thereafter non-branch nia = cia+4.
REQ-030 cia <= nia on every non-stalled cycle.
REQ-031 LK=1: LR <= cia+4 regardless of taken; LR-form target uses the pre-update LR.
REQ-032 Priority: branch LR/CTR update over i_lr_we / i_ctr_we in the same cycle; the mtspr write is dropped.
REQ-033 RAS push on accepted LK=1 with taken, any form except LR-form, value cia+4; full: overwrite oldest entry circularly, depth stays RAS_DEPTH.
REQ-034 RAS pop on accepted, taken LR-form with BH=00 and LK=0; pop when empty: no change, valid stays 0.
REQ-035 bclrl taken with BH=00: pop then push in the same cycle; net depth unchanged, top = cia+4.
REQ-036 Stall: o_next_instr_addr holds its value if i_en=0; no register changes.

Reset
REQ-037 Reset: cia=RESET_ADDR; LR=0; CTR=0; RAS empty; o_taken=0; o_ras_mismatch=0; o_ras_valid=0; boot flag set.
REQ-038 Reset asserted mid-branch SHALL discard the branch; no LR, CTR or RAS update.

Verification
REQ-039 Reset release, i_en=0 for 3 cycles -> nia = 0, 4, 8, 12.
REQ-040 cia=0x100, I-form LI=0x10, AA=0, LK=1 -> nia=0x140, LR=0x104, RAS top=0x104, o_taken=1 next cycle.
REQ-041 CTR=1, bdnz (BO=10000) -> CTR=0, not taken, nia=cia+4; CTR=2 -> CTR=1, taken to BD target.
REQ-042 RAS_DEPTH=8: 9 bl calls, then 9 blr -> first 8 pops match with o_ras_mismatch=0; the 9th asserts o_ras_mismatch with o_ras_valid=0.
REQ-043 i_32b_mode=1, cia=0xFFFF_FFFC, non-branch -> nia=0x0000_0000_0000_0000.
REQ-044 i_stall=1 with i_en=1 -> err_branch_on_stall=1; cia, LR, CTR, RAS unchanged.
